// File: rtl/up_down_counter.sv
// Up/down binary counter with enable, parallel load, synchronous clear,
// wrap or saturate boundary handling and a registered terminal-count pulse.
module up_down_counter #(
    parameter int unsigned            WIDTH    = 4,
    parameter bit                     SATURATE = 1'b0,
    parameter logic [WIDTH-1:0]       RST_VAL  = '0
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             en,
    input  logic             dir,
    input  logic             sclr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             at_max,
    output logic             at_min,
    output logic             tc
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             max_s, min_s;

    assign max_s = &cnt_q;
    assign min_s = ~|cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        if (sclr) begin
            cnt_d = RST_VAL;
        end else if (load) begin
            cnt_d = d;
        end else if (en && dir) begin
            // A step off the top is flagged whether it wraps or is held
            if (max_s) begin
                tc_d  = 1'b1;
                cnt_d = SATURATE ? cnt_q : '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (en) begin
            if (min_s) begin
                tc_d  = 1'b1;
                cnt_d = SATURATE ? cnt_q : '1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q <= RST_VAL;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end

    assign q      = cnt_q;
    assign tc     = tc_q;
    assign at_max = max_s;
    assign at_min = min_s;

endmodule

// File: tb/tb_up_down_counter.sv
// Directed-vector bench for up_down_counter: a wrapping instance and a
// saturating instance share the clock and reset.
module tb_up_down_counter;

    typedef struct {
        bit       sat;
        bit       sclr;
        bit       load;
        bit       en;
        bit       dir;
        bit [3:0] d;
        bit [3:0] q;
        bit       tc;
    } vec_t;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;

    logic       en0 = 0, dir0 = 0, sclr0 = 0, load0 = 0;
    logic [3:0] d0 = '0;
    logic [3:0] q0;
    logic       mx0, mn0, tc0;

    logic       en1 = 0, dir1 = 0, sclr1 = 0, load1 = 0;
    logic [3:0] d1 = '0;
    logic [3:0] q1;
    logic       mx1, mn1, tc1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    up_down_counter #(.WIDTH(4), .SATURATE(1'b0), .RST_VAL(4'd0)) u_wrap (
        .clk(clk), .arst_n(arst_n), .en(en0), .dir(dir0),
        .sclr(sclr0), .load(load0), .d(d0),
        .q(q0), .at_max(mx0), .at_min(mn0), .tc(tc0)
    );

    up_down_counter #(.WIDTH(4), .SATURATE(1'b1), .RST_VAL(4'd0)) u_sat (
        .clk(clk), .arst_n(arst_n), .en(en1), .dir(dir1),
        .sclr(sclr1), .load(load1), .d(d1),
        .q(q1), .at_max(mx1), .at_min(mn1), .tc(tc1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input bit sat,
                           input bit [3:0] eq, input bit etc);
        if (sat) begin
            chk({nm, " q"}, int'(q1), int'(eq));
            chk({nm, " tc"}, int'(tc1), int'(etc));
            chk({nm, " at_max"}, int'(mx1), int'(eq == 4'hF));
            chk({nm, " at_min"}, int'(mn1), int'(eq == 4'h0));
        end else begin
            chk({nm, " q"}, int'(q0), int'(eq));
            chk({nm, " tc"}, int'(tc0), int'(etc));
            chk({nm, " at_max"}, int'(mx0), int'(eq == 4'hF));
            chk({nm, " at_min"}, int'(mn0), int'(eq == 4'h0));
        end
    endtask

    function automatic vec_t mk(bit sat, bit sclr, bit load, bit en, bit dir,
                                bit [3:0] d, bit [3:0] q, bit tc);
        vec_t v;
        v.sat = sat; v.sclr = sclr; v.load = load; v.en = en;
        v.dir = dir; v.d = d; v.q = q; v.tc = tc;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string nm);
        @(negedge clk);
        {en0, dir0, sclr0, load0, d0} = '0;
        {en1, dir1, sclr1, load1, d1} = '0;
        if (v.sat) begin
            en1 = v.en; dir1 = v.dir; sclr1 = v.sclr; load1 = v.load; d1 = v.d;
        end else begin
            en0 = v.en; dir0 = v.dir; sclr0 = v.sclr; load0 = v.load; d0 = v.d;
        end
        @(posedge clk);
        #1;
        chk_out(nm, v.sat, v.q, v.tc);
    endtask

    // Assert reset a few ns after an edge and check it acts before the next one
    task automatic async_reset(input string nm);
        @(posedge clk);
        #3;
        arst_n = 1'b0;
        #1;
        chk_out(nm, 1'b0, 4'd0, 1'b0);
        chk_out({nm, " sat"}, 1'b1, 4'd0, 1'b0);
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    vec_t ta[$];
    vec_t tb[$];
    vec_t tc_tab[$];

    initial begin
        // Count up from reset, then hold/enable and direction switching
        ta.push_back(mk(0, 0, 0, 0, 1, 0, 4'd0, 0));
        ta.push_back(mk(0, 0, 0, 1, 1, 0, 4'd1, 0));
        ta.push_back(mk(0, 0, 0, 1, 1, 0, 4'd2, 0));
        ta.push_back(mk(0, 0, 0, 1, 1, 0, 4'd3, 0));

        tb.push_back(mk(0, 0, 1, 0, 0, 4'd3, 4'd3, 0));
        tb.push_back(mk(0, 0, 0, 0, 0, 0, 4'd3, 0));
        tb.push_back(mk(0, 0, 0, 0, 1, 0, 4'd3, 0));
        tb.push_back(mk(0, 0, 0, 1, 0, 0, 4'd2, 0));
        tb.push_back(mk(0, 0, 0, 1, 1, 0, 4'd3, 0));
        tb.push_back(mk(0, 1, 0, 1, 1, 0, 4'd0, 0));
        tb.push_back(mk(0, 0, 0, 1, 0, 0, 4'd15, 1));
        tb.push_back(mk(0, 0, 0, 1, 1, 0, 4'd0, 1));
        tb.push_back(mk(0, 0, 0, 0, 1, 0, 4'd0, 0));
        tb.push_back(mk(0, 1, 1, 1, 1, 4'd9, 4'd0, 0));
        tb.push_back(mk(0, 0, 1, 1, 1, 4'd9, 4'd9, 0));
        tb.push_back(mk(0, 0, 1, 1, 1, 4'd15, 4'd15, 0));
        tb.push_back(mk(0, 0, 0, 1, 0, 0, 4'd14, 0));
        tb.push_back(mk(0, 0, 0, 1, 1, 0, 4'd15, 0));
        tb.push_back(mk(0, 0, 0, 1, 1, 0, 4'd0, 1));
        tb.push_back(mk(0, 0, 0, 1, 1, 0, 4'd1, 0));
        tb.push_back(mk(0, 0, 0, 1, 0, 0, 4'd0, 0));
        tb.push_back(mk(0, 0, 0, 1, 0, 0, 4'd15, 1));

        // Saturating instance
        tc_tab.push_back(mk(1, 0, 1, 0, 1, 4'd15, 4'd15, 0));
        tc_tab.push_back(mk(1, 0, 0, 1, 1, 0, 4'd15, 1));
        tc_tab.push_back(mk(1, 0, 0, 1, 1, 0, 4'd15, 1));
        tc_tab.push_back(mk(1, 0, 0, 0, 1, 0, 4'd15, 0));
        tc_tab.push_back(mk(1, 0, 0, 1, 0, 0, 4'd14, 0));
        tc_tab.push_back(mk(1, 0, 1, 1, 0, 4'd0, 4'd0, 0));
        tc_tab.push_back(mk(1, 0, 0, 1, 0, 0, 4'd0, 1));
        tc_tab.push_back(mk(1, 0, 0, 1, 0, 0, 4'd0, 1));
        tc_tab.push_back(mk(1, 0, 0, 1, 1, 0, 4'd1, 0));
        tc_tab.push_back(mk(1, 1, 1, 1, 1, 4'd7, 4'd0, 0));

        // Reset held with the clock running
        #12;
        chk_out("reset", 1'b0, 4'd0, 1'b0);
        chk_out("reset sat", 1'b1, 4'd0, 1'b0);
        @(negedge clk);
        arst_n = 1'b1;

        foreach (ta[i]) apply(ta[i], $sformatf("A%0d", i));
        async_reset("async mid-count");
        foreach (tb[i]) apply(tb[i], $sformatf("B%0d", i));
        // Last B vector left tc=1; reset must clear it immediately
        async_reset("async clears tc");
        foreach (tc_tab[i]) apply(tc_tab[i], $sformatf("S%0d", i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/up_down_counter.md
Name: up_down_counter

Overview:
- Synchronous binary up/down counter with clock enable, direction select, parallel load, synchronous clear and terminal-count flags.
- General-purpose counting primitive for the counter library (event counting, address stepping, timers).
- Single clock domain; asynchronous active-low reset.

Parameters:
- WIDTH, 4, counter width in bits (legal range 1..32).
- SATURATE, 0, 0 = wrap at the boundaries; 1 = hold at all-ones when counting up and at zero when counting down.
- RST_VAL, 0, value loaded into q by reset and by sclr (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- arst_n  input  1  asynchronous reset, active-low. Named after the codebase's `arst`; the `_n` suffix marks the fixed active-low polarity.
- en  input  1  count enable; counts only when 1.
- dir  input  1  direction; 1 = up, 0 = down.
- sclr  input  1  synchronous clear to RST_VAL (tie 0 if unused).
- load  input  1  synchronous parallel load (tie 0 if unused).
- d  input  WIDTH  load value.
- q  output  WIDTH  registered count.
- at_max  output  1  combinational; 1 when q == all-ones.
- at_min  output  1  combinational; 1 when q == 0.
- tc  output  1  registered; 1-cycle pulse on the cycle after a wrap or saturation-boundary hit.

Behaviour:
- Reset:
  - arst_n = 0 immediately forces q = RST_VAL and tc = 0, independent of clk.
  - Reset is held for as long as arst_n = 0; all inputs are ignored meanwhile.
  - On release, the first rising clk edge with arst_n = 1 is processed normally.
  - Reset asserted mid-count aborts the count at once; no partial update.
- Priority on each rising clk edge (arst_n = 1), highest first:
  1. sclr: q <= RST_VAL.
  2. load: q <= d.
  3. en & dir: q <= q + 1.
  4. en & ~dir: q <= q - 1.
  5. Otherwise q holds.
- Latency: q reflects the operation one clock after the sampling edge. Inputs are sampled only at rising edges.
- Arithmetic: unsigned modulo 2^WIDTH.
- Wrap mode (SATURATE = 0):
  - all-ones +1 -> 0.
  - 0 -1 -> all-ones.
- Saturate mode (SATURATE = 1):
  - Up at all-ones holds all-ones.
  - Down at 0 holds 0.
- tc is set to 1 for exactly one cycle when an enabled count step (not sclr/load) either wraps or attempts to move past a boundary while saturated. Otherwise tc is 0.
- at_max and at_min are decoded directly from q. Both are 0 except at the boundaries. With WIDTH = 1 they are mutually exclusive as normal.
- A dir change while en = 1 takes effect on the next edge; there is no dead cycle.
- en = 0 holds q, and tc = 0.
- X/Z inputs are unsupported.

Test Plan:
- Reset: arst_n = 0 for 10 ns with clk toggling -> q = 0, at_min = 1, tc = 0. Release, en = 0, dir = 1, one edge -> q stays 0.
- Count up: en = 1, dir = 1, three rising edges from 0 -> q = 1, 2, 3. Assert arst_n = 0 between edges -> q = 0 immediately, without a clock edge.
- Hold/enable: q = 3, en = 0 for 2 edges -> q = 3. Then en = 1, dir = 0 -> q = 2; switch dir = 1 next edge -> q = 3.
- Wrap (SATURATE = 0, WIDTH = 4): from 0, en = 1, dir = 0, one edge -> q = 15, tc = 1 for one cycle, at_max = 1. Next up edge -> q = 0, tc = 1.
- Saturate (SATURATE = 1): load d = 15, then 2 up edges -> q = 15 both cycles, tc pulses per blocked step. Down from 0 -> q = 0.
- Priority: sclr = 1, load = 1, d = 9, en = 1 on the same edge -> q = 0. load = 1, d = 9, en = 1 -> q = 9.
